// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults and width helpers for the VC input buffer
package router_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int NUM_VC_DEF = 2;
    localparam int DEPTH_DEF  = 4;

    // VC index width; a single bit is kept even for a one-VC build
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // occupancy width must hold the value DEPTH itself
    function automatic int cnt_width(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int VC_W  = vc_width(NUM_VC_DEF);
    localparam int CNT_W = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/router_vc_fifo.sv
// rtl/router_vc_fifo.sv - single-clock FIFO holding the flits of one virtual channel
module router_vc_fifo
    import router_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // storage is not reset: the count guards against stale entries being read out
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_vc_input_buffer.sv
// rtl/router_vc_input_buffer.sv - per-VC input buffering with a registered drain port
module router_vc_input_buffer
    import router_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NUM_VC = NUM_VC_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int VC_W   = vc_width(NUM_VC),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_send,
    input  logic [VC_W-1:0]         in_vc,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_VC-1:0]       in_ready,
    input  logic [VC_W-1:0]         out_vc,
    input  logic                    out_blocked,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [VC_W-1:0]         out_vc_id,
    output logic [NUM_VC*CNT_W-1:0] vc_count,
    output logic                    err_overflow
);

    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] pop_vec;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [DATA_W-1:0] head [NUM_VC];
    logic [DATA_W-1:0] head_sel;
    logic              pop_any;
    logic              send_drop;

    // an out-of-range VC index matches no lane, so it neither pushes nor pops
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [CNT_W-1:0] cnt;

        assign push_vec[v] = in_send & (in_vc == VC_W'(v)) & ~full[v];
        assign pop_vec[v]  = ~out_blocked & (out_vc == VC_W'(v)) & ~empty[v];
        assign vc_count[v*CNT_W +: CNT_W] = cnt;

        router_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_vec[v]),
            .push_data (in_data),
            .pop       (pop_vec[v]),
            .head_data (head[v]),
            .full      (full[v]),
            .empty     (empty[v]),
            .count     (cnt)
        );
    end

    assign in_ready  = ~full;
    assign pop_any   = |pop_vec;
    assign send_drop = in_send & ~(|push_vec);

    // at most one lane pops per cycle, so selecting by the pop vector is one-hot
    always_comb begin
        head_sel = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (pop_vec[v]) begin
                head_sel = head[v];
            end
        end
    end

    // output register: popped flit is presented on the edge of the pop, zeros otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc_id <= '0;
        end else if (pop_any) begin
            out_valid <= 1'b1;
            out_data  <= head_sel;
            out_vc_id <= out_vc;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc_id <= '0;
        end
    end

    // sticky drop flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow <= 1'b0;
        end else if (send_drop) begin
            err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_vc_input_buffer.sv
// tb/tb_router_vc_input_buffer.sv - randomized model-checked bench for the VC input buffer
module tb_router_vc_input_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    int          which;
    logic        t_send;
    int          t_vc;
    logic [63:0] t_data;
    int          t_ovc;
    logic        t_blk;

    int checks;
    int errors;

    // reference model: one queue per VC
    int          mn;
    int          md;
    logic [63:0] mq [8][$];
    logic        mer;
    logic [67:0] exp_out;

    // instance A: 2 VCs, depth 4
    logic        in_send_a;
    logic [0:0]  in_vc_a;
    logic [63:0] in_data_a;
    logic [1:0]  in_ready_a;
    logic [0:0]  out_vc_a;
    logic        out_blocked_a;
    logic        out_valid_a;
    logic [63:0] out_data_a;
    logic [0:0]  out_vc_id_a;
    logic [5:0]  vc_count_a;
    logic        err_a;

    // instance B: 4 VCs, depth 8
    logic        in_send_b;
    logic [1:0]  in_vc_b;
    logic [63:0] in_data_b;
    logic [3:0]  in_ready_b;
    logic [1:0]  out_vc_b;
    logic        out_blocked_b;
    logic        out_valid_b;
    logic [63:0] out_data_b;
    logic [1:0]  out_vc_id_b;
    logic [15:0] vc_count_b;
    logic        err_b;

    assign in_send_a     = (which == 0) & t_send;
    assign in_vc_a       = t_vc[0:0];
    assign in_data_a     = t_data;
    assign out_vc_a      = t_ovc[0:0];
    assign out_blocked_a = (which != 0) | t_blk;

    assign in_send_b     = (which == 1) & t_send;
    assign in_vc_b       = t_vc[1:0];
    assign in_data_b     = t_data;
    assign out_vc_b      = t_ovc[1:0];
    assign out_blocked_b = (which != 1) | t_blk;

    router_vc_input_buffer #(.DATA_W(64), .NUM_VC(2), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .in_send(in_send_a), .in_vc(in_vc_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .out_vc(out_vc_a), .out_blocked(out_blocked_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_vc_id(out_vc_id_a),
        .vc_count(vc_count_a), .err_overflow(err_a)
    );

    router_vc_input_buffer #(.DATA_W(64), .NUM_VC(4), .DEPTH(8)) dut_b (
        .clk(clk), .reset(reset), .in_send(in_send_b), .in_vc(in_vc_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .out_vc(out_vc_b), .out_blocked(out_blocked_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_vc_id(out_vc_id_b),
        .vc_count(vc_count_b), .err_overflow(err_b)
    );

    function automatic logic [67:0] obs_out();
        if (which == 0) return {out_valid_a, 2'b00, out_vc_id_a, out_data_a};
        return {out_valid_b, 1'b0, out_vc_id_b, out_data_b};
    endfunction

    function automatic int obs_cnt(input int v);
        if (which == 0) return int'(vc_count_a[v*3 +: 3]);
        return int'(vc_count_b[v*4 +: 4]);
    endfunction

    function automatic logic [7:0] obs_ready();
        if (which == 0) return {6'b0, in_ready_a};
        return {4'b0, in_ready_b};
    endfunction

    function automatic logic obs_err();
        return (which == 0) ? err_a : err_b;
    endfunction

    function automatic logic [7:0] exp_ready();
        logic [7:0] r;
        r = '0;
        for (int v = 0; v < mn; v++) r[v] = (mq[v].size() < md);
        return r;
    endfunction

    // one clock of stimulus; the model advances from the queue state seen before the edge
    task automatic step(input logic s, input int vc, input logic [63:0] d, input int ovc, input logic blk);
        logic        pop_ok;
        logic        push_ok;
        logic [63:0] popped;
        t_send = s; t_vc = vc; t_data = d; t_ovc = ovc; t_blk = blk;
        @(posedge clk);
        pop_ok  = !blk && ovc < mn && mq[ovc].size() > 0;
        push_ok = s && vc < mn && mq[vc].size() < md;
        if (s && !push_ok) mer = 1'b1;
        popped = '0;
        if (pop_ok) popped = mq[ovc].pop_front();
        exp_out = pop_ok ? {1'b1, 3'(ovc), popped} : 68'd0;
        if (push_ok) mq[vc].push_back(d);
        #1;
        t_send = 1'b0; t_blk = 1'b1;
    endtask

    // reset edge with random traffic presented, which must be ignored
    task automatic do_reset();
        reset = 1'b1;
        t_send = 1'b1; t_vc = $urandom_range(0, mn - 1); t_data = {$urandom, $urandom};
        t_ovc = $urandom_range(0, mn - 1); t_blk = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t_send = 1'b0; t_blk = 1'b1;
        for (int v = 0; v < 8; v++) mq[v].delete();
        mer = 1'b0;
        exp_out = '0;
    endtask

    task automatic test_reset();
        which = 0; mn = 2; md = 4;
        do_reset();
        checks++;
        if (obs_out() !== 68'd0) begin
            errors++; $display("FAIL reset_out got=%h exp=0", obs_out());
        end
        checks++;
        if (obs_ready() !== 8'h03) begin
            errors++; $display("FAIL reset_ready got=%h exp=03", obs_ready());
        end
        checks++;
        if (vc_count_a !== 6'd0) begin
            errors++; $display("FAIL reset_count got=%h exp=0", vc_count_a);
        end
        checks++;
        if (obs_err() !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b exp=0", obs_err());
        end
    endtask

    task automatic test_latency();
        step(1'b1, 0, 64'hA1, 0, 1'b0);
        checks++;
        if (obs_out() !== 68'd0) begin
            errors++; $display("FAIL latency_no_bypass got=%h exp=0", obs_out());
        end
        step(1'b0, 0, 64'h0, 0, 1'b0);
        checks++;
        if (obs_out() !== {1'b1, 3'd0, 64'hA1} || exp_out !== {1'b1, 3'd0, 64'hA1}) begin
            errors++; $display("FAIL latency_out got=%h exp=%h", obs_out(), {1'b1, 3'd0, 64'hA1});
        end
    endtask

    task automatic test_fill_block();
        for (int i = 0; i < 4; i++) step(1'b1, 1, {$urandom, $urandom}, 1, 1'b1);
        checks++;
        if (obs_ready() !== 8'h01) begin
            errors++; $display("FAIL fill_ready got=%h exp=01", obs_ready());
        end
        checks++;
        if (obs_cnt(1) !== 4) begin
            errors++; $display("FAIL fill_count got=%0d exp=4", obs_cnt(1));
        end
        step(1'b1, 1, 64'hDEAD, 1, 1'b1);
        checks++;
        if (obs_err() !== 1'b1 || obs_cnt(1) !== 4) begin
            errors++; $display("FAIL fill_overflow err=%b cnt=%0d exp err=1 cnt=4", obs_err(), obs_cnt(1));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 64'h0, 1, 1'b0);
            checks++;
            if (obs_out() !== exp_out) begin
                errors++; $display("FAIL fill_drain%0d got=%h exp=%h", i, obs_out(), exp_out);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        step(1'b1, 0, {$urandom, $urandom}, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 0, {$urandom, $urandom}, 0, 1'b0);
            checks++;
            if (obs_out() !== exp_out || obs_cnt(0) !== 1) begin
                errors++; $display("FAIL stream%0d got=%h cnt=%0d exp=%h cnt=1", i, obs_out(), obs_cnt(0), exp_out);
            end
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 0, {$urandom, $urandom}, 0, 1'b1);
        step(1'b1, 0, 64'hBAD, 0, 1'b0);
        checks++;
        if (obs_cnt(0) !== 3 || obs_err() !== 1'b1 || obs_out() !== exp_out) begin
            errors++; $display("FAIL full_push_pop cnt=%0d err=%b out=%h exp cnt=3 err=1 out=%h",
                               obs_cnt(0), obs_err(), obs_out(), exp_out);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 64'h0, 0, 1'b0);
            checks++;
            if (obs_out() !== exp_out) begin
                errors++; $display("FAIL full_drain%0d got=%h exp=%h", i, obs_out(), exp_out);
            end
        end
    endtask

    task automatic test_zero_flit();
        do_reset();
        step(1'b1, 1, 64'h0, 1, 1'b0);
        step(1'b0, 0, 64'h0, 1, 1'b0);
        checks++;
        if (obs_out() !== {1'b1, 3'd1, 64'h0}) begin
            errors++; $display("FAIL zero_flit got=%h exp=%h", obs_out(), {1'b1, 3'd1, 64'h0});
        end
        step(1'b0, 0, 64'h0, 1, 1'b0);
        checks++;
        if (obs_out() !== 68'd0) begin
            errors++; $display("FAIL zero_idle got=%h exp=0", obs_out());
        end
    endtask

    // full randomized comparison of every output each cycle
    task automatic run_random(input int cycles, input string tag, input int pop_pct);
        for (int i = 0; i < cycles; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, mn - 1), {$urandom, $urandom},
                 $urandom_range(0, mn - 1), 1'($urandom_range(0, 99) >= pop_pct));
            checks++;
            if (obs_out() !== exp_out) begin
                errors++; $display("FAIL %s_out%0d got=%h exp=%h", tag, i, obs_out(), exp_out);
            end
            checks++;
            if (obs_ready() !== exp_ready() || obs_err() !== mer) begin
                errors++; $display("FAIL %s_flags%0d ready=%h err=%b exp ready=%h err=%b",
                                   tag, i, obs_ready(), obs_err(), exp_ready(), mer);
            end
            for (int v = 0; v < mn; v++) begin
                checks++;
                if (obs_cnt(v) !== mq[v].size()) begin
                    errors++; $display("FAIL %s_cnt%0d vc%0d got=%0d exp=%0d", tag, i, v, obs_cnt(v), mq[v].size());
                end
            end
        end
    endtask

    task automatic test_random_2vc();
        do_reset();
        run_random(200, "rand2", 40);
    endtask

    task automatic test_mid_reset();
        which = 1; mn = 4; md = 8;
        do_reset();
        run_random(40, "pre_rst", 15);
        do_reset();
        checks++;
        if (vc_count_b !== 16'd0 || obs_out() !== 68'd0 || obs_ready() !== 8'h0F) begin
            errors++; $display("FAIL mid_reset cnt=%h out=%h ready=%h exp 0/0/0f", vc_count_b, obs_out(), obs_ready());
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 64'h0, i % 4, 1'b0);
            checks++;
            if (obs_out() !== 68'd0) begin
                errors++; $display("FAIL post_reset_stale%0d got=%h exp=0", i, obs_out());
            end
        end
        run_random(150, "rand4", 50);
    endtask

    initial begin
        checks = 0; errors = 0;
        which = 0; mn = 2; md = 4; mer = 1'b0; exp_out = '0;
        t_send = 1'b0; t_vc = 0; t_data = '0; t_ovc = 0; t_blk = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_fill_block();
        test_stream();
        test_full_push_pop();
        test_zero_flit();
        test_random_2vc();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
